// File: rtl/loteria_jogo_param_pkg.sv
// Shared types and helpers for the parametrised lottery engine.
package loteria_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // Packs a decimal value into up to eight BCD digits, digit 0 in bits [3:0].
  function automatic logic [31:0] dec_to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/loteria_jogo_param_if.sv
// Bet/score bus between the key/switch front end (master) and the game engine (slave).
interface loteria_jogo_param_if #(
  parameter int DIGITS       = 4,
  parameter int MAX_BETS     = 8,
  parameter int PRIZE_DIGITS = 3,
  parameter int TOTAL_DIGITS = 4
);
  localparam int BW = $clog2(MAX_BETS + 1);

  logic [4*DIGITS-1:0]       num;
  logic [4*DIGITS-1:0]       secret;
  logic                      insert;
  logic                      finish;
  logic                      win;
  logic [4*PRIZE_DIGITS-1:0] prize;
  logic [4*TOTAL_DIGITS-1:0] total;
  logic [BW-1:0]             bets;
  logic                      full;
  logic                      done;
  logic                      err;

  modport master (
    output num, secret, insert, finish,
    input  win, prize, total, bets, full, done, err
  );

  modport slave (
    input  num, secret, insert, finish,
    output win, prize, total, bets, full, done, err
  );
endinterface

// File: rtl/loteria_bcd_add.sv
// Saturating multi-digit BCD adder: sum clamps to all-9s instead of wrapping.
module loteria_bcd_add
  import loteria_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [4*N-1:0] a_i,
  input  logic [4*N-1:0] b_i,
  output logic [4*N-1:0] sum_o
);

  always_comb begin
    logic           carry;
    logic [4:0]     s;
    logic [4*N-1:0] raw;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    carry = 1'b0;
    raw   = '0;
    s     = '0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, carry};
      if (s > {1'b0, BCD_MAX_DIGIT}) begin
        s     = s + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      raw[4*i +: 4] = s[3:0];
    end
    sum_o = carry ? {N{BCD_MAX_DIGIT}} : raw;
  end

endmodule

// File: rtl/loteria_jogo_param.sv
// Parametrised lottery engine: edge-detected bet/finish keys, 1-cycle scoring pipeline, BCD totals.
// Optional build macro LOTERIA_BCD_CHECK_EN rejects bets containing a non-BCD nibble.
module loteria_jogo_param
  import loteria_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int MAX_BETS     = 8,
  parameter int BONUS        = 50,
  parameter int PRIZE_DIGITS = 3,
  parameter int TOTAL_DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  loteria_jogo_param_if.slave  bus
);

  localparam int BW = $clog2(MAX_BETS + 1);
  localparam int MW = $clog2(DIGITS + 1);
  localparam int TW = 4 * TOTAL_DIGITS;
  localparam logic [31:0]               BONUS_BCD32 = dec_to_bcd(BONUS);
  localparam logic [4*PRIZE_DIGITS-1:0] BONUS_BCD   = BONUS_BCD32[4*PRIZE_DIGITS-1:0];

  state_e                    state_q, state_d;
  logic                      insert_q, finish_q;
  logic [BW-1:0]             bets_q;
  logic                      s1_valid_q, s1_full_q;
  logic [MW-1:0]             s1_m_q;
  logic [4*PRIZE_DIGITS-1:0] prize_q;
  logic [TW-1:0]             total_q;
  logic                      win_q, err_q;

  logic          ins_e, fin_e, full, digits_ok, accept, reject;
  logic [MW-1:0] match_cnt;

  assign ins_e  = bus.insert & ~insert_q;
  assign fin_e  = bus.finish & ~finish_q;
  assign full   = (bets_q == BW'(MAX_BETS));
  assign accept = ins_e && (state_q != DONE) && !full && digits_ok;
  assign reject = ins_e && (state_q != DONE) && (full || !digits_ok);

`ifdef LOTERIA_BCD_CHECK_EN
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (bus.num[4*i +: 4] > BCD_MAX_DIGIT) digits_ok = 1'b0;
  end
`else
  assign digits_ok = 1'b1;
`endif

  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < DIGITS; i++)
      if (bus.num[4*i +: 4] == bus.secret[4*i +: 4]) match_cnt = match_cnt + MW'(1);
  end

  // A bet and a finish on the same edge still count the bet; the game closes on that edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fin_e) state_d = DONE; else if (accept) state_d = PLAY;
      PLAY:    if (fin_e) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  logic [31:0]               m_bcd32;
  logic [4*PRIZE_DIGITS-1:0] value;
  logic [TW-1:0]             total_sum;

  assign m_bcd32 = dec_to_bcd(32'(s1_m_q));
  assign value   = s1_full_q ? BONUS_BCD : m_bcd32[4*PRIZE_DIGITS-1:0];

  loteria_bcd_add #(.N(TOTAL_DIGITS)) u_total_add (
    .a_i   (total_q),
    .b_i   (TW'(value)),
    .sum_o (total_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      insert_q   <= 1'b0;
      finish_q   <= 1'b0;
      bets_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_full_q  <= 1'b0;
      s1_m_q     <= '0;
      prize_q    <= '0;
      total_q    <= '0;
      win_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      state_q    <= state_d;
      insert_q   <= bus.insert;
      finish_q   <= bus.finish;
      err_q      <= reject;
      s1_valid_q <= accept;
      if (accept) begin
        bets_q    <= bets_q + BW'(1);
        s1_m_q    <= match_cnt;
        s1_full_q <= (match_cnt == MW'(DIGITS));
      end
      if (s1_valid_q) begin
        prize_q <= value;
        total_q <= total_sum;
        win_q   <= win_q | s1_full_q;
      end
    end
  end

  assign bus.win   = win_q;
  assign bus.prize = prize_q;
  assign bus.total = total_q;
  assign bus.bets  = bets_q;
  assign bus.full  = full;
  assign bus.done  = (state_q == DONE);
  assign bus.err   = err_q;

endmodule

// File: doc/loteria_jogo_param.md
Name: loteria_jogo_param

Overview:
Parametrised lottery game engine: the successor to the fixed 4-digit game core. It accepts BCD bets from board switches, scores each bet against a drawn number, and accumulates BCD prize totals. Bets are capped per game. Sits between the switch/key debouncers and the 7-segment display driver; all prize outputs are BCD, ready for per-digit decoding.

Parameters:
DIGITS, 4, BCD digits per bet and per drawn number
MAX_BETS, 8, bets accepted per game before the game is full
BONUS, 50, prize (decimal) for a full match; must be < 10^PRIZE_DIGITS
PRIZE_DIGITS, 3, BCD digits of the per-bet prize output
TOTAL_DIGITS, 4, BCD digits of the accumulated total

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
num  in  4*DIGITS  bet, BCD, digit 0 in bits [3:0]
secret  in  4*DIGITS  drawn number, BCD; sampled per bet
insert  in  1  bet key, level; rising edge detected internally
finish  in  1  end-game key, level; rising edge detected internally
win  out  1  sticky: some bet this game matched all digits
prize  out  4*PRIZE_DIGITS  prize of the last scored bet, BCD
total  out  4*TOTAL_DIGITS  accumulated prize, BCD
bets  out  clog2(MAX_BETS+1)  accepted bet count
full  out  1  bets == MAX_BETS
done  out  1  game finished (state DONE)
err  out  1  one-cycle pulse: bet rejected

Behaviour:
- Reset (async, any time, including mid-scoring): state=IDLE; win=0, prize=0, total=0, bets=0, full=0, done=0, err=0; edge-detect registers=0; pipeline valid=0.
- Edge detect: ins_e = insert & ~insert_q; fin_e likewise. A held key produces one event only.
- FSM states: IDLE (no bets yet), PLAY, DONE.
  - IDLE --accepted bet--> PLAY.
  - IDLE/PLAY --fin_e--> DONE.
  - DONE: stays until reset; ins_e and fin_e are ignored.
- Bet acceptance at edge t requires all of: ins_e, state != DONE, full=0, digits valid.
  - On acceptance: bets increments at t.
  - Stage-1 register captures the match count m (matching digit positions, 0..DIGITS) and the full-match flag.
- Scoring at edge t+1 (latency 1 cycle after bet acceptance):
  - Per-bet value = BONUS if m==DIGITS, else m.
  - prize <= value; total <= total + value (BCD add).
  - win <= win | fullmatch.
- Rejected bet (invalid digit, or full=1 while not DONE): err=1 for exactly the cycle after the edge; no other output changes.
- Simultaneous ins_e and fin_e: the bet is accepted and the state goes to DONE in the same edge; the stage-1 bet is still scored at t+1.
  - done is set at t; total is final at t+1.
- full: asserted in the same cycle that bets reaches MAX_BETS.
- Saturation: total saturates at all-9s (e.g. 9999); it never wraps.
- secret may change between bets; each bet is scored against the value sampled with it.

Optional Feature:
LOTERIA_BCD_CHECK_EN
- Defined: any num nibble > 9 rejects the bet (err pulse, no count, no scoring).
- Undefined: nibbles are not checked; non-BCD values are compared raw; err is raised only for bets while full; check logic is absent.

Decomposition:
- Package loteria_pkg holds:
  - the state enum typedef (IDLE, PLAY, DONE);
  - the bcd_digit_t typedef (4-bit);
  - the localparam BCD_MAX_DIGIT = 9;
  - a function for decimal-to-BCD conversion of BONUS at elaboration.
- Sub-module loteria_bcd_add: parametrised by digit count; saturating BCD adder (a, b -> sum, saturated at all-9s). Instantiated once for total.

Test Plan (defaults; secret=1234):
- Reset, insert num=1234 -> 1 cycle later prize=050, total=0050, win=1, bets=1.
- Then insert 1299 -> prize=002, total=0052, win stays 1; insert 5678 -> prize=000, total=0052.
- Hold insert high for 10 cycles with num=1204 -> exactly one bet: bets+1, prize=003.
- Insert 9 valid bets -> full=1 after the 8th; the 9th gives an err pulse and bets stays 8. Preload total near 9999 via 200 full-match bets with MAX_BETS=255 -> total=9999 (saturation).
- With LOTERIA_BCD_CHECK_EN, insert 12A4 -> err=1 for one cycle, bets and total unchanged. Without the macro -> accepted, prize=003.
- insert and finish edges in the same cycle with num=1234 -> done=1 at t, total=0050 at t+1; a later insert is ignored. Assert reset between clock edges -> all outputs 0 immediately.
